// File: rtl/bcd_timer_scan_pkg.sv
// Shared definitions for the MM:SS BCD timer with multiplexed seven-segment scan.
package bcd_timer_scan_pkg;

    // Active-low segment patterns {a,b,c,d,e,f,g,dp}, dp off.
    localparam logic [7:0] SSD_0    = 8'h03;
    localparam logic [7:0] SSD_1    = 8'h9F;
    localparam logic [7:0] SSD_2    = 8'h25;
    localparam logic [7:0] SSD_3    = 8'h0D;
    localparam logic [7:0] SSD_4    = 8'h99;
    localparam logic [7:0] SSD_5    = 8'h49;
    localparam logic [7:0] SSD_6    = 8'h41;
    localparam logic [7:0] SSD_7    = 8'h1F;
    localparam logic [7:0] SSD_8    = 8'h01;
    localparam logic [7:0] SSD_9    = 8'h09;
    localparam logic [7:0] SSD_DASH = 8'hFD;
    localparam logic [7:0] SSD_OFF  = 8'hFF;

    // Active-low digit enables, digit 0 is sec_lo.
    localparam logic [3:0] EN_D0 = 4'b1110;
    localparam logic [3:0] EN_D1 = 4'b1101;
    localparam logic [3:0] EN_D2 = 4'b1011;
    localparam logic [3:0] EN_D3 = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Same packing as the preset input: {min_hi, min_lo, sec_hi, sec_lo}.
    typedef struct packed {
        logic [3:0] min_hi;
        logic [3:0] min_lo;
        logic [3:0] sec_hi;
        logic [3:0] sec_lo;
    } bcd_time_t;

    localparam bcd_time_t TIME_ZERO = 16'h0000;
    localparam bcd_time_t TIME_ONE  = 16'h0001;

    // Force every digit into its legal range: lo digits 0-9, hi digits 0-5.
    function automatic bcd_time_t clamp_time(input logic [15:0] p);
        bcd_time_t r;
        r.min_hi = (p[15:12] > 4'd5) ? 4'd5 : p[15:12];
        r.min_lo = (p[11:8]  > 4'd9) ? 4'd9 : p[11:8];
        r.sec_hi = (p[7:4]   > 4'd5) ? 4'd5 : p[7:4];
        r.sec_lo = (p[3:0]   > 4'd9) ? 4'd9 : p[3:0];
        return r;
    endfunction

    // Ripple increment; 59:59 wraps to 00:00.
    function automatic bcd_time_t bcd_inc(input bcd_time_t t);
        bcd_time_t r = t;
        if (t.sec_lo != 4'd9) begin
            r.sec_lo = t.sec_lo + 4'd1;
        end else begin
            r.sec_lo = 4'd0;
            if (t.sec_hi != 4'd5) begin
                r.sec_hi = t.sec_hi + 4'd1;
            end else begin
                r.sec_hi = 4'd0;
                if (t.min_lo != 4'd9) begin
                    r.min_lo = t.min_lo + 4'd1;
                end else begin
                    r.min_lo = 4'd0;
                    r.min_hi = (t.min_hi == 4'd5) ? 4'd0 : t.min_hi + 4'd1;
                end
            end
        end
        return r;
    endfunction

    // Ripple decrement; callers never decrement 00:00.
    function automatic bcd_time_t bcd_dec(input bcd_time_t t);
        bcd_time_t r = t;
        if (t.sec_lo != 4'd0) begin
            r.sec_lo = t.sec_lo - 4'd1;
        end else begin
            r.sec_lo = 4'd9;
            if (t.sec_hi != 4'd0) begin
                r.sec_hi = t.sec_hi - 4'd1;
            end else begin
                r.sec_hi = 4'd5;
                if (t.min_lo != 4'd0) begin
                    r.min_lo = t.min_lo - 4'd1;
                end else begin
                    r.min_lo = 4'd9;
                    r.min_hi = (t.min_hi == 4'd0) ? 4'd5 : t.min_hi - 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_timer_scan_bcd2ssd.sv
// Combinational BCD to active-low seven-segment decoder with decimal-point pass-through.
module bcd2ssd
    import bcd_timer_scan_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    logic [7:0] pattern;

    // Digit lookup; anything outside 0-9 shows a dash.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        pattern = SSD_DASH;
        case (bcd_i)
            4'd0:    pattern = SSD_0;
            4'd1:    pattern = SSD_1;
            4'd2:    pattern = SSD_2;
            4'd3:    pattern = SSD_3;
            4'd4:    pattern = SSD_4;
            4'd5:    pattern = SSD_5;
            4'd6:    pattern = SSD_6;
            4'd7:    pattern = SSD_7;
            4'd8:    pattern = SSD_8;
            4'd9:    pattern = SSD_9;
            default: pattern = SSD_DASH;
        endcase
    end

    // dp is active low on the pin, so a lit point clears bit 0.
    assign seg_o = {pattern[7:1], pattern[0] & ~dp_i};

endmodule

// File: rtl/bcd_timer_scan.sv
// MM:SS BCD stopwatch / countdown timer driving a 4-digit scanned seven-segment display.
module bcd_timer_scan
    import bcd_timer_scan_pkg::*;
#(
    parameter int SEG_W = 8,
    parameter int DIG_N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_div,
    input  logic [1:0]       clk_ctl,
    input  logic             start_stop,
    input  logic             clear,
    input  logic             down,
    input  logic [15:0]      preset,
    output logic [SEG_W-1:0] ssd,
    output logic [DIG_N-1:0] ssd_ctl,
    output logic             running,
    output logic             done
);

    state_e     state_q, state_d;
    bcd_time_t  count_q, count_d;
    logic       mode_q, mode_d;
    logic       clk_div_q;
    logic       tick;

    logic [3:0] digit_sel;
    logic [3:0] en_sel;
    logic       dp_sel;
    logic [7:0] seg_dec;

    // Resetting the divider history to 1 keeps a high clk_div at release from looking like an edge.
    assign tick = clk_div & ~clk_div_q;

    // Control and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= TIME_ZERO;
            mode_q    <= 1'b0;
            clk_div_q <= 1'b1;
            running   <= 1'b0;
            done      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values, whatever the statement order.
            state_q   <= state_d;
            count_q   <= count_d;
            mode_q    <= mode_d;
            clk_div_q <= clk_div;
            running   <= (state_d == ST_RUN);
            done      <= (state_d == ST_DONE);
        end
    end

    // Next state and count: clear beats start_stop, start_stop beats tick.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mode_d  = mode_q;
        if (clear) begin
            state_d = ST_IDLE;
            mode_d  = down;
            count_d = down ? clamp_time(preset) : TIME_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_stop) begin
                        mode_d  = down;
                        state_d = (down && count_q == TIME_ZERO) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (start_stop) begin
                        state_d = ST_PAUSE;
                    end else if (tick) begin
                        if (!mode_q) begin
                            count_d = bcd_inc(count_q);
                        end else if (count_q == TIME_ONE || count_q == TIME_ZERO) begin
                            count_d = TIME_ZERO;
                            state_d = ST_DONE;
                        end else begin
                            count_d = bcd_dec(count_q);
                        end
                    end
                end
                ST_PAUSE: begin
                    if (start_stop) state_d = ST_RUN;
                end
                ST_DONE: begin
                    count_d = TIME_ZERO;
                end
            endcase
        end
    end

    // Digit mux driven by the divider's scan select; the colon rides on min_lo's dp.
    always_comb begin
        digit_sel = count_q.sec_lo;
        en_sel    = EN_D0;
        dp_sel    = 1'b0;
        case (clk_ctl)
            2'd0: begin digit_sel = count_q.sec_lo; en_sel = EN_D0; end
            2'd1: begin digit_sel = count_q.sec_hi; en_sel = EN_D1; end
            2'd2: begin digit_sel = count_q.min_lo; en_sel = EN_D2; dp_sel = 1'b1; end
            2'd3: begin digit_sel = count_q.min_hi; en_sel = EN_D3; end
        endcase
    end

    bcd2ssd u_bcd2ssd (
        .bcd_i (digit_sel),
        .dp_i  (dp_sel),
        .seg_o (seg_dec)
    );

    // Registered display outputs; DONE blanks the segments during the low half of clk_div.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ssd     <= SSD_OFF;
            ssd_ctl <= 4'hF;
        end else begin
            ssd     <= (state_q == ST_DONE && !clk_div) ? SSD_OFF : seg_dec;
            ssd_ctl <= en_sel;
        end
    end

endmodule

// File: tb/tb_bcd_timer_scan.sv
// Self-checking bench for bcd_timer_scan: directed corner sequences, a preset/decoder table,
// and a randomized phase compared against a seconds-based reference model.
module tb_bcd_timer_scan;

    logic        clk, rst, clk_div, start_stop, clear, down;
    logic [1:0]  clk_ctl;
    logic [15:0] preset;
    logic [7:0]  ssd;
    logic [3:0]  ssd_ctl;
    logic        running, done;

    int checks   = 0;
    int failures = 0;

    bcd_timer_scan dut (
        .clk        (clk),
        .rst        (rst),
        .clk_div    (clk_div),
        .clk_ctl    (clk_ctl),
        .start_stop (start_stop),
        .clear      (clear),
        .down       (down),
        .preset     (preset),
        .ssd        (ssd),
        .ssd_ctl    (ssd_ctl),
        .running    (running),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] seg_tab [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                                 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};
    logic [3:0] en_tab  [4]  = '{4'hE, 4'hD, 4'hB, 4'h7};

    typedef struct {
        logic [15:0]     preset;
        logic [3:0][7:0] exp;   // [0]=sec_lo ... [3]=min_hi
    } vec_t;
    vec_t vecs [4];

    // Reference model: count kept as plain seconds 0..3599.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    int m_state, m_sec;
    bit m_mode, m_div_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] seg_exp(input int d, input bit dp);
        return dp ? (seg_tab[d] & 8'hFE) : seg_tab[d];
    endfunction

    task automatic pulse_ss();
        start_stop = 1'b1; step(); start_stop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; step(); clear = 1'b0;
    endtask

    task automatic do_tick();
        clk_div = 1'b0; step();
        clk_div = 1'b1; step();
    endtask

    // Scan all four digits with clk_div high (no blink, no tick) and compare.
    task automatic check_time(input string name, input int mh, input int ml, input int sh, input int sl);
        int d [4];
        d = '{sl, sh, ml, mh};
        clk_div = 1'b1;
        for (int k = 0; k < 4; k++) begin
            clk_ctl = 2'(k);
            step();
            check({name, "_ssd"}, ssd, seg_exp(d[k], k == 2));
            check({name, "_ctl"}, ssd_ctl, en_tab[k]);
        end
    endtask

    function automatic int clamp_secs(input logic [15:0] p);
        int mh, ml, sh, sl;
        mh = (p[15:12] > 5) ? 5 : int'(p[15:12]);
        ml = (p[11:8]  > 9) ? 9 : int'(p[11:8]);
        sh = (p[7:4]   > 5) ? 5 : int'(p[7:4]);
        sl = (p[3:0]   > 9) ? 9 : int'(p[3:0]);
        return (mh * 10 + ml) * 60 + sh * 10 + sl;
    endfunction

    function automatic logic [7:0] model_disp(input logic [1:0] sel, input bit div);
        int d;
        if (m_state == M_DONE && !div) return 8'hFF;
        case (sel)
            2'd0: d = m_sec % 10;
            2'd1: d = (m_sec % 60) / 10;
            2'd2: d = (m_sec / 60) % 10;
            default: d = m_sec / 600;
        endcase
        return seg_exp(d, sel == 2'd2);
    endfunction

    task automatic model_step(input bit clr, input bit ss, input bit tk, input bit dn, input logic [15:0] pre);
        if (clr) begin
            m_state = M_IDLE;
            m_mode  = dn;
            m_sec   = dn ? clamp_secs(pre) : 0;
        end else begin
            case (m_state)
                M_IDLE: if (ss) begin
                    m_mode  = dn;
                    m_state = (dn && m_sec == 0) ? M_DONE : M_RUN;
                end
                M_RUN: if (ss) m_state = M_PAUSE;
                       else if (tk) begin
                           if (!m_mode) m_sec = (m_sec + 1) % 3600;
                           else if (m_sec <= 1) begin m_sec = 0; m_state = M_DONE; end
                           else m_sec = m_sec - 1;
                       end
                M_PAUSE: if (ss) m_state = M_RUN;
                default: ;
            endcase
        end
    endtask

    initial begin
        logic [7:0] exp_ssd;
        logic [3:0] exp_ctl;
        bit         tk;

        vecs[0] = '{16'h2345, {8'h25, 8'h0C, 8'h99, 8'h49}};
        vecs[1] = '{16'h5967, {8'h49, 8'h08, 8'h49, 8'h1F}};
        vecs[2] = '{16'h0818, {8'h03, 8'h00, 8'h9F, 8'h01}};
        vecs[3] = '{16'hFFF6, {8'h49, 8'h08, 8'h49, 8'h41}};

        rst = 1'b1; clk_div = 1'b1; clk_ctl = 2'd0;
        start_stop = 1'b0; clear = 1'b0; down = 1'b0; preset = 16'h0000;
        step(); step();
        rst = 1'b0;
        step();

        // 1: reset asserted mid-run, released with clk_div high.
        pulse_ss();
        do_tick(); do_tick();
        rst = 1'b1;
        #1;
        check("rst_async_ssd", ssd, 8'hFF);
        check("rst_async_ctl", ssd_ctl, 4'hF);
        check("rst_async_run", running, 1'b0);
        step(); step();
        rst = 1'b0;
        check("rst_ssd", ssd, 8'hFF);
        check("rst_ctl", ssd_ctl, 4'hF);
        check("rst_running", running, 1'b0);
        check("rst_done", done, 1'b0);
        check_time("rst_count", 0, 0, 0, 0);

        // 2: count up 61 seconds.
        down = 1'b0;
        pulse_ss();
        check("up_running", running, 1'b1);
        for (int i = 0; i < 61; i++) do_tick();
        check_time("up_0101", 0, 1, 0, 1);
        clk_ctl = 2'd2; step();
        check("up_colon_ssd", ssd, 8'h9E);
        check("up_colon_ctl", ssd_ctl, 4'hB);

        // 3: wrap from 59:59.
        for (int i = 61; i < 3599; i++) do_tick();
        check_time("up_5959", 5, 9, 5, 9);
        do_tick();
        check_time("up_wrap", 0, 0, 0, 0);
        check("wrap_running", running, 1'b1);

        // Preset load and segment decode table (down mode clear, clamping).
        down = 1'b1;
        foreach (vecs[v]) begin
            preset = vecs[v].preset;
            pulse_clear();
            for (int k = 0; k < 4; k++) begin
                clk_ctl = 2'(k);
                step();
                check($sformatf("tab%0d_ssd%0d", v, k), ssd, vecs[v].exp[k]);
                check($sformatf("tab%0d_ctl%0d", v, k), ssd_ctl, en_tab[k]);
            end
        end

        // 4: countdown from 00:03.
        preset = 16'h0003;
        pulse_clear();
        pulse_ss();
        do_tick(); do_tick();
        check("dn_done_early", done, 1'b0);
        check("dn_running", running, 1'b1);
        do_tick();
        check("dn_done", done, 1'b1);
        check("dn_not_running", running, 1'b0);
        do_tick(); do_tick();
        check_time("dn_hold", 0, 0, 0, 0);
        clk_div = 1'b0; clk_ctl = 2'd0; step();
        check("blink_ssd", ssd, 8'hFF);
        check("blink_ctl", ssd_ctl, 4'hE);
        clk_div = 1'b1; step();
        check("blink_on_ssd", ssd, 8'h03);

        // 5: start_stop coincident with tick at 00:05.
        down = 1'b0;
        pulse_clear();
        pulse_ss();
        for (int i = 0; i < 5; i++) do_tick();
        clk_div = 1'b0; step();
        clk_div = 1'b1; start_stop = 1'b1; step();
        start_stop = 1'b0;
        check("coinc_paused", running, 1'b0);
        check_time("coinc_0005", 0, 0, 0, 5);
        do_tick(); do_tick(); do_tick();
        check_time("pause_hold", 0, 0, 0, 5);
        pulse_ss();
        check("resume_running", running, 1'b1);
        do_tick();
        check_time("resume_0006", 0, 0, 0, 6);

        // 6: clear and start_stop together in RUN, clamped preset.
        down = 1'b1; preset = 16'h7A99;
        pulse_clear();
        pulse_ss();
        check("c6_running", running, 1'b1);
        clear = 1'b1; start_stop = 1'b1; step();
        clear = 1'b0; start_stop = 1'b0;
        check("c6_idle_running", running, 1'b0);
        check("c6_idle_done", done, 1'b0);
        check_time("c6_clamp", 5, 9, 5, 9);

        // Randomized phase against the reference model.
        rst = 1'b1; clk_div = 1'b1; step();
        rst = 1'b0;
        m_state = M_IDLE; m_sec = 0; m_mode = 1'b0; m_div_prev = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            clear      = ($urandom_range(0, 49) == 0);
            start_stop = ($urandom_range(0, 9) == 0);
            clk_div    = 1'($urandom_range(0, 1));
            clk_ctl    = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) down = 1'($urandom_range(0, 1));
            preset = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
            exp_ssd = model_disp(clk_ctl, clk_div);
            exp_ctl = en_tab[clk_ctl];
            tk = clk_div && !m_div_prev;
            model_step(clear, start_stop, tk, down, preset);
            m_div_prev = clk_div;
            step();
            check("rnd_ssd", ssd, exp_ssd);
            check("rnd_ctl", ssd_ctl, exp_ctl);
            check("rnd_running", running, m_state == M_RUN);
            check("rnd_done", done, m_state == M_DONE);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
